hazard_stall_ctrl: RTL

Pipeline hazard and stall controller for the 5-stage 32-bit MIPS core. Sits beside the IF/ID and ID/EXE pipeline registers. Detects load-use hazards, sequences multi-cycle multiply/divide occupancy of EXE, and flushes wrong-path instructions on taken branches. Drives PC write enable, IF/ID write/flush, and a bubble select that zeroes the WB/MEM/EXE control fields entering ID/EXE.

---
 rtl/hazard_stall_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Load-use, mult/div occupancy and taken-branch stall/flush controller for the 5-stage pipeline.
// Optional macro HAZARD_PERF_CNT_EN adds the stall_cycles saturating performance counter output.
module hazard_stall_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_md_start,
    input  logic [4:0]  exe_rt,
    input  logic        exe_mem_read,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idexe_bubble,
    output logic        exmem_flush,
    output logic        md_busy,
    output logic        md_abort,
    output logic        dbg_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               lu;

    // Register zero is never a real producer, so it cannot create a load-use hazard.
    assign lu = exe_mem_read && (exe_rt != 5'd0) &&
                ((exe_rt == id_rs) || (id_uses_rt && (exe_rt == id_rt)));

    assign dbg_state = (state == MD_BUSY);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idexe_bubble = 1'b0;
        exmem_flush  = 1'b0;
        md_busy      = 1'b0;
        md_abort     = 1'b0;

        if (branch_taken) begin
            ifid_flush   = 1'b1;
            idexe_bubble = 1'b1;
            exmem_flush  = 1'b1;
            if (state == MD_BUSY) begin
                md_abort   = 1'b1;
                state_next = RUN;
                cnt_next   = '0;
            end
        end else if (state == MD_BUSY) begin
            md_busy      = 1'b1;
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idexe_bubble = 1'b1;
            cnt_next     = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                state_next = RUN;
            end
        end else if (lu) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idexe_bubble = 1'b1;
        end else if (id_md_start) begin
            // The start cycle itself is not a stall; occupancy covers the remaining cycles.
            state_next = MD_BUSY;
            cnt_next   = CNT_W'(MD_LATENCY - 1);
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (!pc_write && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
